tc_array: RTL

Parametrised multi-channel timer/counter peripheral: the successor to the fixed two-instance timer pair on the CPU bridge. It provides NUM_CH independent down-counters behind one word-addressed register window, each with:
- a prescaler;
- one-shot or auto-reload mode;
- a write-1-to-clear pending flag and a per-channel interrupt mask.

Per-channel and aggregated interrupt lines feed the CPU's external interrupt inputs.

---
 rtl/tc_pkg.sv | 27 ++
 rtl/tc_channel.sv | 159 +++++++++++++++
 rtl/tc_array.sv | 61 ++++++
 3 files changed

// File: rtl/tc_pkg.sv
// Shared definitions for the tc_array timer/counter peripheral.
//   - tc_state_e : per-channel FSM state encoding
//   - REG_*      : register offsets within a channel's 4-word block
//   - CTRL_*     : CTRL register bit positions
//   - MODE_*     : CTRL.MODE codes
package tc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2
  } tc_state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_BIT = 1;
  localparam int CTRL_IM_BIT   = 2;
  localparam int CTRL_PSC_LSB  = 8;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/tc_channel.sv
// One timer channel: CTRL/PRESET registers, prescaler, down-counter FSM and
// write-1-to-clear pending flag.
// Ports:
//   clk      in  clock, rising edge
//   reset    in  asynchronous active-low reset
//   we       in  write strobe, already qualified with this channel's select
//   reg_off  in  register offset (CTRL/PRESET/COUNT/STATUS)
//   din      in  write data
//   rdata    out read data for reg_off (combinational)
//   irq      out pending & IM
//
// state | meaning
// IDLE  | counter stopped, COUNT held
// LOAD  | COUNT <- PRESET, prescaler cleared
// CNT   | counting down one step per prescaler tick
module tc_channel
  import tc_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PSC_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  reg_off,
  input  logic [31:0] din,
  output logic [31:0] rdata,
  output logic        irq
);

  tc_state_e        state_q, state_d;
  logic             en_q, en_d;
  logic             mode_q, mode_d;
  logic             im_q, im_d;
  logic [PSC_W-1:0] prescale_q, prescale_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             pending_q, pending_d;

  logic ctrl_wr, preset_wr, status_wr;
  logic tick, fire;
  logic unused_din;

  assign unused_din = ^din;

  assign ctrl_wr   = we && (reg_off == REG_CTRL);
  assign preset_wr = we && (reg_off == REG_PRESET);
  assign status_wr = we && (reg_off == REG_STATUS);

  assign tick = (psc_q >= prescale_q);
  // PRESET 0 loads COUNT=0, which fires on the first tick exactly like 1.
  assign fire = (state_q == ST_CNT) && tick && (count_q <= CNT_W'(1));

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    mode_d     = mode_q;
    im_d       = im_q;
    prescale_d = prescale_q;
    preset_d   = preset_q;
    count_d    = count_q;
    psc_d      = psc_q;
    pending_d  = pending_q;

    // Clear first so a fire at the same edge overrides it.
    if (status_wr && din[0]) pending_d = 1'b0;

    if (preset_wr) preset_d = din[CNT_W-1:0];

    unique case (state_q)
      ST_LOAD: begin
        count_d = preset_q;
        psc_d   = '0;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (tick) begin
          psc_d = '0;
          if (fire) begin
            pending_d = 1'b1;
            if (mode_q == MODE_ONESHOT) begin
              count_d = '0;
              en_d    = 1'b0;
              state_d = ST_IDLE;
            end else begin
              count_d = preset_q;
            end
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end else begin
          psc_d = psc_q + PSC_W'(1);
        end
      end
      default: ;
    endcase

    // A CTRL write overrides the FSM's state/count decisions, but a
    // simultaneous fire has already set pending above.
    if (ctrl_wr) begin
      mode_d     = din[CTRL_MODE_BIT];
      im_d       = din[CTRL_IM_BIT];
      prescale_d = din[CTRL_PSC_LSB +: PSC_W];
      if (!din[CTRL_EN_BIT]) begin
        en_d    = 1'b0;
        state_d = ST_IDLE;
        count_d = count_q;
        psc_d   = psc_q;
      end else if (!en_q) begin
        en_d    = 1'b1;
        state_d = ST_LOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      mode_q     <= MODE_ONESHOT;
      im_q       <= 1'b0;
      prescale_q <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      psc_q      <= '0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      im_q       <= im_d;
      prescale_q <= prescale_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      psc_q      <= psc_d;
      pending_q  <= pending_d;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (reg_off)
      REG_CTRL: begin
        rdata[CTRL_EN_BIT]             = en_q;
        rdata[CTRL_MODE_BIT]           = mode_q;
        rdata[CTRL_IM_BIT]             = im_q;
        rdata[CTRL_PSC_LSB +: PSC_W]   = prescale_q;
      end
      REG_PRESET: rdata = 32'(preset_q);
      REG_COUNT:  rdata = 32'(count_q);
      REG_STATUS: rdata[0] = pending_q;
      default: ;
    endcase
  end

  assign irq = pending_q & im_q;

endmodule

// File: rtl/tc_array.sv
// Multi-channel timer/counter peripheral: NUM_CH tc_channel instances behind
// one word-addressed register window (channel = addr[ADDR_W-1:2],
// register = addr[1:0]).
// Ports:
//   clk      in  clock, rising edge
//   reset    in  asynchronous active-low reset
//   addr     in  word address within the window
//   we       in  write strobe
//   din      in  write data
//   dout     out read data, combinational from addr; 0 for absent channels
//   irq_vec  out per-channel interrupt
//   irq      out OR of irq_vec
module tc_array
  import tc_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int PSC_W  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq
);

  logic [31:0] ch_idx;
  logic [31:0] rdata [NUM_CH];

  // Zero-extended so indices beyond NUM_CH simply match no channel.
  assign ch_idx = 32'(addr[ADDR_W-1:2]);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tc_channel #(
      .CNT_W (CNT_W),
      .PSC_W (PSC_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .we      (we && (ch_idx == 32'(g))),
      .reg_off (addr[1:0]),
      .din     (din),
      .rdata   (rdata[g]),
      .irq     (irq_vec[g])
    );
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == 32'(i)) dout = rdata[i];
    end
  end

  assign irq = |irq_vec;

endmodule
